// File: rtl/assign_style_compare_monitor.sv
// Compares the blocking and non-blocking assignment-style circuit outputs sample by sample
// and keeps a registered record of the first divergence.
module assign_style_compare_monitor #(
  parameter int unsigned W      = 4,
  parameter int unsigned CW     = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [W-1:0]    a_blk_i,
  input  logic [W-1:0]    c_blk_i,
  input  logic [W-1:0]    a_nblk_i,
  input  logic [W-1:0]    c_nblk_i,
  output logic [1:0]      state_o,
  output logic            diverged_o,
  output logic [CW-1:0]   sample_cnt_o,
  output logic [CW-1:0]   mismatch_cnt_o,
  output logic [CW-1:0]   first_idx_o,
  output logic [2*W-1:0]  first_diff_o
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StSettle   = 2'd1,
    StMatch    = 2'd2,
    StDiverged = 2'd3
  } state_e;

  localparam logic [CW-1:0] CntMax  = '1;
  localparam logic [CW:0]   SettleW = (CW+1)'(SETTLE);

  state_e          state_q, state_d;
  logic            diverged_q, diverged_d;
  logic [CW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [CW-1:0]   mismatch_cnt_q, mismatch_cnt_d;
  logic [CW-1:0]   first_idx_q, first_idx_d;
  logic [2*W-1:0]  first_diff_q, first_diff_d;

  logic            compare;
  logic            mismatch;
  logic            settle_last;
  logic [2*W-1:0]  diff_vec;

  // sample_cnt_q is the index k of the sample being taken this cycle
  assign compare     = {1'b0, sample_cnt_q} >= SettleW;
  assign settle_last = ({1'b0, sample_cnt_q} + 1'b1) >= SettleW;
  assign diff_vec    = {a_blk_i ^ a_nblk_i, c_blk_i ^ c_nblk_i};
  assign mismatch    = compare && ((a_blk_i != a_nblk_i) || (c_blk_i != c_nblk_i));

  // Next-state values assume a sample is being taken; the register block gates on en_i
  always_comb begin
    state_d        = state_q;
    diverged_d     = diverged_q;
    sample_cnt_d   = (sample_cnt_q == CntMax) ? sample_cnt_q : sample_cnt_q + 1'b1;
    mismatch_cnt_d = mismatch_cnt_q;
    first_idx_d    = first_idx_q;
    first_diff_d   = first_diff_q;

    if (mismatch) begin
      if (mismatch_cnt_q != CntMax) begin
        mismatch_cnt_d = mismatch_cnt_q + 1'b1;
      end
      if (!diverged_q) begin
        diverged_d   = 1'b1;
        first_idx_d  = sample_cnt_q;
        first_diff_d = diff_vec;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (SETTLE > 1)    state_d = StSettle;
        else if (mismatch) state_d = StDiverged;
        else               state_d = StMatch;
      end
      StSettle: begin
        if (settle_last) state_d = StMatch;
      end
      StMatch: begin
        if (mismatch) state_d = StDiverged;
      end
      StDiverged: state_d = StDiverged;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_q        <= StIdle;
      diverged_q     <= 1'b0;
      sample_cnt_q   <= '0;
      mismatch_cnt_q <= '0;
      first_idx_q    <= '0;
      first_diff_q   <= '0;
    end else if (en_i) begin
      state_q        <= state_d;
      diverged_q     <= diverged_d;
      sample_cnt_q   <= sample_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      first_idx_q    <= first_idx_d;
      first_diff_q   <= first_diff_d;
    end
  end

  assign state_o        = state_q;
  assign diverged_o     = diverged_q;
  assign sample_cnt_o   = sample_cnt_q;
  assign mismatch_cnt_o = mismatch_cnt_q;
  assign first_idx_o    = first_idx_q;
  assign first_diff_o   = first_diff_q;

endmodule
